ac_register_unit: RTL and testbench
===================================

# ac_register_unit

Accumulator datapath that executes the AC control strobes produced by the control-signal decoder. Holds the 16-bit AC and the E (extended carry) flip-flop and performs the logic, arithmetic, shift and I/O micro-operations selected each clock. Sits between the control unit and the common bus. DR supplies the memory operand and INPR supplies the input character.

## Interface
Parameters:
- `WIDTH`, default 16: AC and DR width. Must be at least 9.
- `IN_WIDTH`, default 8: INPR width. Must not exceed `WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `DR`  in  WIDTH  memory operand.
- `INPR`  in  IN_WIDTH  input character register.
- `LD`  in  1  load AC from the ALU result selected by the op lines.
- `AND`, `ADD`, `LDA`, `SUB`, `OR`, `XOR`  in  1 each  ALU op select, qualified by `LD`.
- `INC`  in  1  AC ← AC+1.
- `CLR`  in  1  AC ← 0.
- `CMA`  in  1  AC ← ~AC.
- `CLE`  in  1  E ← 0.
- `CME`  in  1  E ← ~E.
- `CIR`  in  1  circulate {AC,E} right.
- `CIL`  in  1  circulate {AC,E} left.
- `INP`  in  1  AC[IN_WIDTH-1:0] ← INPR.
- `AC`  out  WIDTH  accumulator (registered).
- `E`  out  1  extended carry flip-flop (registered).
- `AC_ZERO`  out  1  AC == 0.
- `AC_NEG`  out  1  AC[WIDTH-1].
- `OVF`  out  1  overflow flag. Present only with `AC_OVERFLOW_EN`.

## Operation
AC writes are decided by one priority chain, highest first:
- `CLR`
- `LD`
- `INC`
- `CMA`
- `CIR`
- `CIL`
- `INP`
- hold

Under `LD`, the op select follows its own priority: `ADD` > `SUB` > `AND` > `OR` > `XOR` > `LDA`. If `LD` is asserted with no op line, AC holds.

Op results:
- `ADD`: {E,AC} ← AC + DR, a (WIDTH+1)-bit sum.
- `SUB`: {E,AC} ← AC + ~DR + 1. E is the carry-out, so E=1 means no borrow.
- `AND`, `OR`, `XOR`: bitwise with DR. E unchanged.
- `LDA`: AC ← DR. E unchanged.
- `INC`: AC ← AC+1, wrapping all-ones to 0. E unchanged.
- `CIR`: AC ← {E, AC[WIDTH-1:1]}, E ← AC[0].
- `CIL`: AC ← {AC[WIDTH-2:0], E}, E ← AC[WIDTH-1].
- `INP`: loads the low IN_WIDTH bits only. Upper bits are unchanged.

E writes:
- An E write from the winning AC op (ADD, SUB, CIR, CIL) overrides `CLE`/`CME`.
- Otherwise `CLE` > `CME`.
- E-only ops may coincide with a non-E AC op in the same cycle; both take effect.

Flags:
- `AC_ZERO` and `AC_NEG` are combinational from the AC register.

## Timing
- All state updates on the rising `clk` edge in which the strobe is high. The result is visible on `AC`/`E` in the next cycle; latency is 1 cycle.
- Strobes are single-cycle levels sampled every edge. There is no handshake and no busy state, so back-to-back ops each take one cycle.
- `rst` high at an edge: AC=0, E=0, OVF=0. Reset overrides every strobe. After reset, `AC_ZERO`=1 and `AC_NEG`=0.
- Flags follow AC in the same cycle; they have no extra register stage.

## Configuration
- `AC_OVERFLOW_EN` defined: adds port `OVF` and a sticky overflow register.
  - Set on signed two's-complement overflow of ADD or SUB: operand signs agree (for SUB, AC vs ~DR) and the result sign differs.
  - Cleared by `rst` or `CLR`. Holds otherwise.
- Undefined: no `OVF` port and no register. All other behaviour is identical.

## Structure
- Shared package `ac_pkg`:
  - `AC_WIDTH`=16 and `IN_WIDTH`=8 constants.
  - Enum `ac_op_t`: NONE, ADD, SUB, AND, OR, XOR, LDA, INC, CLR, CMA, CIR, CIL, INP.
  - Function that priority-encodes the strobes into `ac_op_t`.
- One combinational sub-module, `ac_alu`:
  - Inputs: AC, E, DR, INPR, `ac_op_t`.
  - Outputs: next AC, next E, E-write enable, overflow.
- Top level holds the AC/E/OVF registers, the E-only logic and the flags.

## Test plan
- Reset: assert `rst` with `LD`+`ADD`, DR=16'h1234 → AC=0, E=0, `AC_ZERO`=1. Releasing `rst`, then `LD`+`LDA` with DR=16'h8001 → next cycle AC=16'h8001, `AC_NEG`=1.
- Add carry: AC=16'hFFFF, E=0; `LD`+`ADD`, DR=16'h0001 → AC=0, E=1, `AC_ZERO`=1. Then `LD`+`SUB`, DR=16'h0001 → AC=16'hFFFF, E=0.
- Rotate: AC=16'h8001, E=0; `CIL` → AC=16'h0002, E=1. Then `CIR` → AC=16'h8001, E=0.
- Priority: AC=16'h00F0; `CLR`+`INC`+`CMA` same cycle → AC=0. Then `INC`+`CME` with E=0 → AC=1, E=1. Then `LD`+`AND`+`OR`, DR=16'h0003 → AC=16'h0001 (AND wins).
- INP/INC wrap: AC=16'hAB00; `INP`, INPR=8'h5A → AC=16'hAB5A. AC=16'hFFFF; `INC` → AC=0, E unchanged.
- Overflow (`AC_OVERFLOW_EN`): AC=16'h7FFF; `LD`+`ADD`, DR=1 → AC=16'h8000, OVF=1. OVF holds through a following `LDA`; `CLR` → OVF=0.

Source files
------------

// File: rtl/ac_register_unit_pkg.sv
// ac_pkg: shared definitions for the accumulator datapath.
//   AC_WIDTH / IN_WIDTH : default AC and INPR widths.
//   ac_op_t             : the single AC micro-operation selected in a cycle.
//   ac_decode()         : priority-encodes the raw control strobes into ac_op_t.
package ac_pkg;

  localparam int unsigned AC_WIDTH = 16;
  localparam int unsigned IN_WIDTH = 8;

  typedef enum logic [3:0] {
    NONE,
    ADD,
    SUB,
    AND,
    OR,
    XOR,
    LDA,
    INC,
    CLR,
    CMA,
    CIR,
    CIL,
    INP
  } ac_op_t;

  // AC chain: CLR > LD > INC > CMA > CIR > CIL > INP.
  // Under LD: ADD > SUB > AND > OR > XOR > LDA; LD with no op line holds AC.
  function automatic ac_op_t ac_decode(
    input logic ld,
    input logic op_and,
    input logic op_add,
    input logic op_lda,
    input logic op_sub,
    input logic op_or,
    input logic op_xor,
    input logic inc,
    input logic clr,
    input logic cma,
    input logic cir,
    input logic cil,
    input logic inp
  );
    ac_op_t op;
    op = NONE;
    if (clr) begin
      op = CLR;
    end else if (ld) begin
      if (op_add)      op = ADD;
      else if (op_sub) op = SUB;
      else if (op_and) op = AND;
      else if (op_or)  op = OR;
      else if (op_xor) op = XOR;
      else if (op_lda) op = LDA;
      else             op = NONE;
    end else if (inc) begin
      op = INC;
    end else if (cma) begin
      op = CMA;
    end else if (cir) begin
      op = CIR;
    end else if (cil) begin
      op = CIL;
    end else if (inp) begin
      op = INP;
    end
    return op;
  endfunction

endpackage

// File: rtl/ac_register_unit_alu.sv
// ac_alu: combinational result generator for one AC micro-operation.
//   ac_i, e_i   : current AC and E.
//   dr_i        : memory operand.
//   inpr_i      : input character.
//   op_i        : decoded operation.
//   ac_o        : next AC (equals ac_i when op_i is NONE).
//   e_o, e_we_o : next E and its write enable (ADD, SUB, CIR, CIL only).
//   ovf_o       : signed overflow of ADD/SUB.
module ac_alu
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH    = ac_pkg::AC_WIDTH,
  parameter int unsigned IN_WIDTH = ac_pkg::IN_WIDTH
) (
  input  logic [WIDTH-1:0]    ac_i,
  input  logic                e_i,
  input  logic [WIDTH-1:0]    dr_i,
  input  logic [IN_WIDTH-1:0] inpr_i,
  input  ac_op_t              op_i,
  output logic [WIDTH-1:0]    ac_o,
  output logic                e_o,
  output logic                e_we_o,
  output logic                ovf_o
);

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] dr_n;

  assign dr_n    = ~dr_i;
  assign sum_add = {1'b0, ac_i} + {1'b0, dr_i};
  // Carry-out of AC + ~DR + 1 is the "no borrow" flag.
  assign sum_sub = {1'b0, ac_i} + {1'b0, dr_n} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    ac_o   = ac_i;
    e_o    = e_i;
    e_we_o = 1'b0;
    ovf_o  = 1'b0;
    unique case (op_i)
      ADD: begin
        {e_o, ac_o} = sum_add;
        e_we_o      = 1'b1;
        ovf_o       = (ac_i[WIDTH-1] == dr_i[WIDTH-1]) &&
                      (sum_add[WIDTH-1] != ac_i[WIDTH-1]);
      end
      SUB: begin
        {e_o, ac_o} = sum_sub;
        e_we_o      = 1'b1;
        ovf_o       = (ac_i[WIDTH-1] == dr_n[WIDTH-1]) &&
                      (sum_sub[WIDTH-1] != ac_i[WIDTH-1]);
      end
      AND: ac_o = ac_i & dr_i;
      OR:  ac_o = ac_i | dr_i;
      XOR: ac_o = ac_i ^ dr_i;
      LDA: ac_o = dr_i;
      INC: ac_o = ac_i + {{(WIDTH-1){1'b0}}, 1'b1};
      CLR: ac_o = '0;
      CMA: ac_o = ~ac_i;
      CIR: begin
        ac_o   = {e_i, ac_i[WIDTH-1:1]};
        e_o    = ac_i[0];
        e_we_o = 1'b1;
      end
      CIL: begin
        ac_o   = {ac_i[WIDTH-2:0], e_i};
        e_o    = ac_i[WIDTH-1];
        e_we_o = 1'b1;
      end
      INP: ac_o[IN_WIDTH-1:0] = inpr_i;
      default: ac_o = ac_i;
    endcase
  end

endmodule

// File: rtl/ac_register_unit.sv
// ac_register_unit: accumulator (AC) and extended-carry (E) registers driven
// by the control-unit strobes.
//   clk, rst          : rising-edge clock, synchronous active-high reset.
//   DR, INPR          : memory operand, input character.
//   LD + AND/ADD/LDA/SUB/OR/XOR : load AC from the selected ALU op.
//   INC, CLR, CMA, CIR, CIL, INP : AC micro-ops.
//   CLE, CME          : E-only ops, combinable with a non-E AC op.
//   AC, E             : registered state.
//   AC_ZERO, AC_NEG   : combinational flags from AC.
//   OVF               : sticky signed overflow, only when AC_OVERFLOW_EN is defined.
module ac_register_unit #(
  parameter int unsigned WIDTH    = ac_pkg::AC_WIDTH,
  parameter int unsigned IN_WIDTH = ac_pkg::IN_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    DR,
  input  logic [IN_WIDTH-1:0] INPR,
  input  logic                LD,
  input  logic                AND,
  input  logic                ADD,
  input  logic                LDA,
  input  logic                SUB,
  input  logic                OR,
  input  logic                XOR,
  input  logic                INC,
  input  logic                CLR,
  input  logic                CMA,
  input  logic                CLE,
  input  logic                CME,
  input  logic                CIR,
  input  logic                CIL,
  input  logic                INP,
  output logic [WIDTH-1:0]    AC,
  output logic                E,
  output logic                AC_ZERO,
  output logic                AC_NEG
`ifdef AC_OVERFLOW_EN
  ,
  output logic                OVF
`endif
);

  import ac_pkg::*;

  logic [WIDTH-1:0] ac_q;
  logic             e_q;
  logic             e_d;
  ac_op_t           op;
  logic [WIDTH-1:0] alu_ac;
  logic             alu_e;
  logic             alu_e_we;
  logic             ovf_set;

  assign op = ac_decode(LD, AND, ADD, LDA, SUB, OR, XOR,
                        INC, CLR, CMA, CIR, CIL, INP);

  ac_alu #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH)
  ) u_alu (
    .ac_i   (ac_q),
    .e_i    (e_q),
    .dr_i   (DR),
    .inpr_i (INPR),
    .op_i   (op),
    .ac_o   (alu_ac),
    .e_o    (alu_e),
    .e_we_o (alu_e_we),
    .ovf_o  (ovf_set)
  );

  // An E write from the winning AC op beats CLE/CME.
  always_comb begin
    e_d = e_q;
    if (alu_e_we)  e_d = alu_e;
    else if (CLE)  e_d = 1'b0;
    else if (CME)  e_d = ~e_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q <= '0;
      e_q  <= 1'b0;
    end else begin
      ac_q <= alu_ac;
      e_q  <= e_d;
    end
  end

`ifdef AC_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst || CLR) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end

  assign OVF = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_set;
`endif

  assign AC      = ac_q;
  assign E       = e_q;
  assign AC_ZERO = (ac_q == '0);
  assign AC_NEG  = ac_q[WIDTH-1];

endmodule

// File: tb/tb_ac_register_unit.sv
module tb_ac_register_unit;

  localparam logic [14:0] S_LD  = 15'h0001;
  localparam logic [14:0] S_AND = 15'h0002;
  localparam logic [14:0] S_ADD = 15'h0004;
  localparam logic [14:0] S_LDA = 15'h0008;
  localparam logic [14:0] S_SUB = 15'h0010;
  localparam logic [14:0] S_OR  = 15'h0020;
  localparam logic [14:0] S_XOR = 15'h0040;
  localparam logic [14:0] S_INC = 15'h0080;
  localparam logic [14:0] S_CLR = 15'h0100;
  localparam logic [14:0] S_CMA = 15'h0200;
  localparam logic [14:0] S_CLE = 15'h0400;
  localparam logic [14:0] S_CME = 15'h0800;
  localparam logic [14:0] S_CIR = 15'h1000;
  localparam logic [14:0] S_CIL = 15'h2000;
  localparam logic [14:0] S_INP = 15'h4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dr;
  logic [7:0]  inpr;
  logic [14:0] st;
  logic [15:0] ac;
  logic        e, ac_zero, ac_neg;
  logic        ovf;

  typedef struct {
    string       tag;
    logic [15:0] ac;
    logic        e;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_ac  = '0;
  logic        m_e   = 1'b0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  ac_register_unit #(
    .WIDTH    (16),
    .IN_WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .DR      (dr),
    .INPR    (inpr),
    .LD      (st[0]),
    .AND     (st[1]),
    .ADD     (st[2]),
    .LDA     (st[3]),
    .SUB     (st[4]),
    .OR      (st[5]),
    .XOR     (st[6]),
    .INC     (st[7]),
    .CLR     (st[8]),
    .CMA     (st[9]),
    .CLE     (st[10]),
    .CME     (st[11]),
    .CIR     (st[12]),
    .CIL     (st[13]),
    .INP     (st[14]),
    .AC      (ac),
    .E       (e),
    .AC_ZERO (ac_zero),
    .AC_NEG  (ac_neg)
`ifdef AC_OVERFLOW_EN
    ,
    .OVF     (ovf)
`endif
  );

`ifndef AC_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input logic rst_v, input logic [14:0] st_v, input logic [15:0] dr_v,
                      input logic [7:0] inpr_v, input string tag,
                      input logic [15:0] eac, input logic ee, input logic eovf);
    exp_t x;
    @(negedge clk);
    rst  = rst_v;
    st   = st_v;
    dr   = dr_v;
    inpr = inpr_v;
    sb.push_back('{tag, eac, ee, eovf});
    m_ac = eac; m_e = ee; m_ovf = eovf;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".ac"},   {16'h0, ac},      {16'h0, x.ac});
    chk({x.tag, ".e"},    {31'h0, e},       {31'h0, x.e});
    chk({x.tag, ".zero"}, {31'h0, ac_zero}, {31'h0, (x.ac == 16'h0)});
    chk({x.tag, ".neg"},  {31'h0, ac_neg},  {31'h0, x.ac[15]});
`ifdef AC_OVERFLOW_EN
    chk({x.tag, ".ovf"},  {31'h0, ovf},     {31'h0, x.ovf});
`endif
  endtask

  // Independent reference model for the random phase.
  task automatic model(input logic rst_v, input logic [14:0] s, input logic [15:0] d,
                       input logic [7:0] ip, output logic [15:0] nac,
                       output logic ne, output logic nov);
    logic [16:0] t;
    logic        ew;
    logic        vs;
    nac = m_ac; ne = m_e; nov = m_ovf; ew = 1'b0; vs = 1'b0;
    if ((s & S_CLR) != 0) nac = 16'h0;
    else if ((s & S_LD) != 0) begin
      if ((s & S_ADD) != 0) begin
        t = m_ac + d; nac = t[15:0]; ne = t[16]; ew = 1'b1;
        vs = ($signed(m_ac) + $signed(d) > 32767) || ($signed(m_ac) + $signed(d) < -32768);
      end else if ((s & S_SUB) != 0) begin
        t = {1'b0, m_ac} + {1'b0, ~d} + 17'd1; nac = t[15:0]; ne = t[16]; ew = 1'b1;
        vs = ($signed(m_ac) - $signed(d) > 32767) || ($signed(m_ac) - $signed(d) < -32768);
      end else if ((s & S_AND) != 0) nac = m_ac & d;
      else if ((s & S_OR)  != 0) nac = m_ac | d;
      else if ((s & S_XOR) != 0) nac = m_ac ^ d;
      else if ((s & S_LDA) != 0) nac = d;
    end
    else if ((s & S_INC) != 0) nac = m_ac + 16'd1;
    else if ((s & S_CMA) != 0) nac = ~m_ac;
    else if ((s & S_CIR) != 0) begin nac = {m_e, m_ac[15:1]}; ne = m_ac[0]; ew = 1'b1; end
    else if ((s & S_CIL) != 0) begin nac = {m_ac[14:0], m_e}; ne = m_ac[15]; ew = 1'b1; end
    else if ((s & S_INP) != 0) nac = {m_ac[15:8], ip};
    if (!ew) begin
      if ((s & S_CLE) != 0) ne = 1'b0;
      else if ((s & S_CME) != 0) ne = ~m_e;
    end
    if ((s & S_CLR) != 0) nov = 1'b0;
    else if (vs) nov = 1'b1;
    if (rst_v) begin nac = 16'h0; ne = 1'b0; nov = 1'b0; end
  endtask

  initial begin
    logic [15:0] eac;
    logic        ee, eo;
    logic [14:0] rs;
    logic [15:0] rd;
    logic [7:0]  ri;
    rst = 1'b1; st = '0; dr = '0; inpr = '0;

    // Reset overrides LD+ADD.
    step(1, S_LD | S_ADD, 16'h1234, 8'h00, "reset",    16'h0000, 0, 0);
    step(0, S_LD | S_LDA, 16'h8001, 8'h00, "lda_neg",  16'h8001, 0, 0);
    // Carry out of ADD, borrow on SUB.
    step(0, S_LD | S_LDA, 16'hFFFF, 8'h00, "lda_ffff", 16'hFFFF, 0, 0);
    step(0, S_LD | S_ADD, 16'h0001, 8'h00, "add_cy",   16'h0000, 1, 0);
    step(0, S_LD | S_SUB, 16'h0001, 8'h00, "sub_brw",  16'hFFFF, 0, 0);
    // Rotates; LDA and CLE combine.
    step(0, S_LD | S_LDA | S_CLE, 16'h8001, 8'h00, "lda_cle", 16'h8001, 0, 0);
    step(0, S_CIL, 16'h0000, 8'h00, "cil",      16'h0002, 1, 0);
    step(0, S_CIR, 16'h0000, 8'h00, "cir",      16'h8001, 0, 0);
    // Priority.
    step(0, S_LD | S_LDA, 16'h00F0, 8'h00, "lda_f0",   16'h00F0, 0, 0);
    step(0, S_CLR | S_INC | S_CMA, 16'h0000, 8'h00, "clr_pri", 16'h0000, 0, 0);
    step(0, S_INC | S_CME, 16'h0000, 8'h00, "inc_cme",  16'h0001, 1, 0);
    step(0, S_LD | S_AND | S_OR, 16'h0003, 8'h00, "and_pri", 16'h0001, 1, 0);
    step(0, S_LD | S_ADD | S_SUB, 16'h0002, 8'h00, "add_pri", 16'h0003, 0, 0);
    step(0, S_LD, 16'h5555, 8'h00, "ld_noop",  16'h0003, 0, 0);
    // INP keeps upper bits; INC wraps with E untouched.
    step(0, S_LD | S_LDA | S_CME, 16'hAB00, 8'h00, "lda_ab", 16'hAB00, 1, 0);
    step(0, S_INP, 16'h0000, 8'h5A, "inp",      16'hAB5A, 1, 0);
    step(0, S_LD | S_LDA, 16'hFFFF, 8'h00, "lda_ff2",  16'hFFFF, 1, 0);
    step(0, S_INC, 16'h0000, 8'h00, "inc_wrap", 16'h0000, 1, 0);
    // E write from ADD beats CLE; CLE beats CME.
    step(0, S_LD | S_LDA, 16'hFFFF, 8'h00, "lda_ff3",  16'hFFFF, 1, 0);
    step(0, S_LD | S_ADD | S_CLE, 16'h0001, 8'h00, "add_cle", 16'h0000, 1, 0);
    step(0, S_CLE | S_CME | S_CMA, 16'h0000, 8'h00, "cle_cme", 16'hFFFF, 0, 0);
    // Overflow (checked only when the port exists).
    step(0, S_LD | S_LDA, 16'h7FFF, 8'h00, "lda_7f",   16'h7FFF, 0, 0);
    step(0, S_LD | S_ADD, 16'h0001, 8'h00, "add_ovf",  16'h8000, 0, 1);
    step(0, S_LD | S_LDA, 16'h1234, 8'h00, "ovf_hold", 16'h1234, 0, 1);
    step(0, S_CLR, 16'h0000, 8'h00, "ovf_clr",  16'h0000, 0, 0);
    step(0, S_LD | S_LDA, 16'h8000, 8'h00, "lda_80",   16'h8000, 0, 0);
    step(0, S_LD | S_SUB, 16'h0001, 8'h00, "sub_ovf",  16'h7FFF, 1, 1);
    step(1, S_INC, 16'h0000, 8'h00, "ovf_rst",  16'h0000, 0, 0);

    // Random mixes against the reference model.
    for (int i = 0; i < 60; i++) begin
      rs = 15'($urandom & $urandom & $urandom);
      if ((i % 3) == 0) rs = rs | S_LD;
      rd = 16'($urandom);
      ri = 8'($urandom);
      model(1'b0, rs, rd, ri, eac, ee, eo);
      step(0, rs, rd, ri, "rand", eac, ee, eo);
    end

    @(negedge clk);
    st = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
